// File: rtl/piano_mode_mux.sv
// Selects one playing-mode engine onto the shared note/LED/octave/number outputs, with a mute gap
// on mode changes, a fault state for illegal modes and an edge-toggled play state.
// Optional: define PIANO_MODE_MUX_SCORE_EN to register the selected competition player's score.
module piano_mode_mux #(
    parameter int unsigned          NUM_SRC     = 4,
    parameter int unsigned          NOTE_W      = 4,
    parameter int unsigned          LED_W       = 7,
    parameter int unsigned          OCT_W       = 2,
    parameter int unsigned          NUM_W       = 4,
    parameter int unsigned          MUTE_CYCLES = 16,
    parameter logic [NOTE_W-1:0]    REST_NOTE   = '0,
    parameter logic [OCT_W-1:0]     DEFAULT_OCT = 2'd1,
    parameter logic [LED_W-1:0]     FAULT_LED   = 7'h7F
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_SRC-1:0]          mode,
    input  logic                        start,
    input  logic                        user,
    input  logic [NUM_SRC*NOTE_W-1:0]   src_note,
    input  logic [NUM_SRC*LED_W-1:0]    src_led,
    input  logic [NUM_SRC*OCT_W-1:0]    src_octave,
    input  logic [NUM_SRC*NUM_W-1:0]    src_num,
    input  logic [3:0]                  score_a,
    input  logic [3:0]                  score_b,
    output logic [NOTE_W-1:0]           note_out,
    output logic [LED_W-1:0]            led_out,
    output logic [OCT_W-1:0]            octave_out,
    output logic [NUM_W-1:0]            num,
    output logic [3:0]                  score_user,
    output logic                        play_state,
    output logic [$clog2(NUM_SRC)-1:0]  active_src,
    output logic                        switching
);
    localparam int unsigned      SRC_W    = $clog2(NUM_SRC);
    localparam int unsigned      CNT_W    = (MUTE_CYCLES > 1) ? $clog2(MUTE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUTE_CYCLES - 1);

    typedef enum logic [1:0] {StFault, StMute, StRun} state_e;

    state_e              state_q, state_d;
    logic [NUM_SRC-1:0]  mode_q, cur_q, cur_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                start_q, start_q2;
    logic                play_q, play_d;
    logic [NOTE_W-1:0]   note_q, note_d, sel_note;
    logic [LED_W-1:0]    led_q, led_d, sel_led;
    logic [OCT_W-1:0]    oct_q, oct_d, sel_oct;
    logic [NUM_W-1:0]    num_q, num_d, sel_num;
    logic [SRC_W-1:0]    src_q, src_d, cur_idx;
    logic                switching_q, switching_d;
    logic                mode_legal, mode_new, start_rise;

    assign mode_legal = $onehot(mode_q);
    assign mode_new   = (mode_q != cur_q);
    assign start_rise = start_q & ~start_q2;

    // cur_q is the one-hot mode whose gap or run is in progress.
    always_comb begin
        cur_idx = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (cur_q[i]) cur_idx = SRC_W'(i);
        end
    end

    always_comb begin
        sel_note = '0;
        sel_led  = '0;
        sel_oct  = '0;
        sel_num  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (cur_idx == SRC_W'(i)) begin
                sel_note = src_note[i*NOTE_W +: NOTE_W];
                sel_led  = src_led[i*LED_W +: LED_W];
                sel_oct  = src_octave[i*OCT_W +: OCT_W];
                sel_num  = src_num[i*NUM_W +: NUM_W];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        cnt_d       = cnt_q;
        play_d      = play_q;
        note_d      = note_q;
        led_d       = led_q;
        oct_d       = oct_q;
        num_d       = num_q;
        src_d       = src_q;
        switching_d = switching_q;

        if (!mode_legal) begin
            state_d     = StFault;
            note_d      = REST_NOTE;
            led_d       = FAULT_LED;
            oct_d       = DEFAULT_OCT;
            num_d       = '0;
            src_d       = '0;
            switching_d = 1'b0;
            play_d      = 1'b0;
        end else if (state_q == StFault || mode_new) begin
            // New or changed mode: (re)start the gap; a coincident start edge is dropped.
            state_d     = StMute;
            cur_d       = mode_q;
            cnt_d       = CNT_LOAD;
            note_d      = REST_NOTE;
            led_d       = '0;
            oct_d       = DEFAULT_OCT;
            num_d       = '0;
            switching_d = 1'b1;
            play_d      = 1'b0;
        end else if (state_q == StMute) begin
            if (cnt_q == '0) begin
                state_d     = StRun;
                src_d       = cur_idx;
                note_d      = sel_note;
                led_d       = sel_led;
                oct_d       = sel_oct;
                num_d       = sel_num;
                switching_d = 1'b0;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end else begin
            note_d = sel_note;
            led_d  = sel_led;
            oct_d  = sel_oct;
            num_d  = sel_num;
            if (start_rise) play_d = ~play_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StFault;
            mode_q      <= '0;
            cur_q       <= '0;
            cnt_q       <= '0;
            start_q     <= 1'b0;
            start_q2    <= 1'b0;
            play_q      <= 1'b0;
            note_q      <= REST_NOTE;
            led_q       <= FAULT_LED;
            oct_q       <= DEFAULT_OCT;
            num_q       <= '0;
            src_q       <= '0;
            switching_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode;
            cur_q       <= cur_d;
            cnt_q       <= cnt_d;
            start_q     <= start;
            start_q2    <= start_q;
            play_q      <= play_d;
            note_q      <= note_d;
            led_q       <= led_d;
            oct_q       <= oct_d;
            num_q       <= num_d;
            src_q       <= src_d;
            switching_q <= switching_d;
        end
    end

`ifdef PIANO_MODE_MUX_SCORE_EN
    logic [3:0] score_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            score_q <= '0;
        end else if (state_d == StFault) begin
            score_q <= '0;
        end else if (state_q == StRun && state_d == StRun && src_q == SRC_W'(3)) begin
            score_q <= user ? score_a : score_b;
        end
    end

    assign score_user = score_q;
`else
    logic unused_score;
    assign unused_score = ^{user, score_a, score_b};
    assign score_user   = 4'h0;
`endif

    assign note_out   = note_q;
    assign led_out    = led_q;
    assign octave_out = oct_q;
    assign num        = num_q;
    assign play_state = play_q;
    assign active_src = src_q;
    assign switching  = switching_q;

endmodule

// File: doc/piano_mode_mux.md
# piano_mode_mux

Parametrised output selector between the piano's playing-mode engines (free, auto, learn, competition, and further modes) and the shared note/LED/octave/number outputs feeding the buzzer and display drivers. It generalises the fixed four-way selection to `NUM_SRC` sources carried on flattened buses. It adds a timed mute gap on every mode change, so no stale note from the old mode reaches the buzzer. It also adds a fault state for illegal mode codes and an edge-detected start/pause toggle that flips once per press instead of every held cycle.

## Interface
Parameters:
- `NUM_SRC`, 4: number of mode sources; `mode` is one-hot of this width.
- `NOTE_W`, 4: note code width.
- `LED_W`, 7: LED bar width.
- `OCT_W`, 2: octave width.
- `NUM_W`, 4: song-number width.
- `MUTE_CYCLES`, 16: length of the mute gap in clk cycles; must be ≥1.
- `REST_NOTE`, 0: note code meaning silence.
- `DEFAULT_OCT`, 1: octave driven in mute and fault.
- `FAULT_LED`, 7'h7F: LED pattern driven in fault.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high.
- `mode` in `NUM_SRC`: one-hot mode select, level, synchronous to clk.
- `start` in 1: start/pause button, level, already debounced.
- `user` in 1: selects competition player (1 = A, 0 = B).
- `src_note` in `NUM_SRC*NOTE_W`: source i occupies `[i*NOTE_W +: NOTE_W]`.
- `src_led` in `NUM_SRC*LED_W`: same packing.
- `src_octave` in `NUM_SRC*OCT_W`: same packing.
- `src_num` in `NUM_SRC*NUM_W`: same packing.
- `score_a`, `score_b` in 4 each: competition player scores.
- `note_out` out `NOTE_W`; `led_out` out `LED_W`; `octave_out` out `OCT_W`; `num` out `NUM_W`.
- `score_user` out 4: score of the selected player.
- `play_state` out 1: run/pause toggle to the auto and competition engines.
- `active_src` out `$clog2(NUM_SRC)`: index of the source currently driving the outputs.
- `switching` out 1: high during the mute gap.

## Operation
- States are FAULT, MUTE and RUN. `mode_q` holds the last sampled `mode`.
- Reset: state FAULT and `mode_q` = 0. Outputs are `note_out`=`REST_NOTE`, `led_out`=`FAULT_LED`, `octave_out`=`DEFAULT_OCT`, `num`=0, `score_user`=0, `play_state`=0, `active_src`=0, `switching`=0.
- FAULT: entered whenever `mode` is zero or has more than one bit set, from any state. Drives the reset output values except `play_state`, which is cleared. Leaves to MUTE on the first one-hot `mode`.
- MUTE: counter loads `MUTE_CYCLES-1` on entry. Outputs are `REST_NOTE`, LED 0, `DEFAULT_OCT` and num 0, with `switching`=1. If a different one-hot `mode` arrives, the counter reloads. When the counter reaches 0 the block goes to RUN with `active_src` = encode(`mode_q`).
- RUN: registered copy of source `active_src` on all four buses, `switching`=0. A different one-hot `mode` goes to MUTE; an illegal `mode` goes to FAULT.
- `play_state` toggles on the rising edge of `start`, detected from a registered `start`. It is only allowed to toggle in RUN and is cleared on entry to MUTE or FAULT.
- Width rule: all source slices are zero-extended or truncated to nothing. Widths match exactly; slice indices are computed at elaboration time.

## Timing
- RUN latency is 1 cycle from a source bus change to the output.
- A mode change sampled at edge k gives mute outputs from edge k+1. The new source appears at edge k+1+`MUTE_CYCLES`.
- A `start` rising edge sampled at edge k gives `play_state` flipped at edge k+1. A held `start` never re-toggles.
- If a mode change and a start edge occur in the same cycle, the mode change wins: `play_state` is cleared.
- Reset mid-gap aborts to FAULT immediately, asynchronously.

## Configuration
- `PIANO_MODE_MUX_SCORE_EN` defined: `score_user` is registered as `user ? score_a : score_b`. It updates in RUN only when `active_src` = 3 (competition) and holds its value otherwise.
- Not defined: `score_user` is constant 0 and the score inputs are unused.

## Test plan
- Reset, then set `mode`=4'b0001 with `MUTE_CYCLES`=4 and source 0 note 5 → `switching`=1 for 4 cycles, then `note_out`=5 and `active_src`=0.
- In RUN on source 0, set `mode`=4'b0100 with source 2 note 9 and LED 7'h01 → 4 cycles of note 0 and LED 0, then note 9 and LED 7'h01.
- Hold `start` high for 10 cycles in RUN → `play_state` goes 0→1 once. A second press gives 1→0.
- Set `mode`=4'b0011 in RUN → next cycle `led_out`=7'h7F and `note_out`=0. Then `mode`=4'b1000 → mute gap, then source 3.
- Change `mode` 0001→0010→0100 two cycles apart during MUTE → the gap restarts and ends on source 2.
- With `PIANO_MODE_MUX_SCORE_EN`, `mode`=4'b1000, `score_a`=7, `score_b`=3: toggle `user` 1→0 → `score_user` goes 7→3. Without the macro, `score_user` stays 0.
